// File: rtl/key_debounce_multi.sv
// N-key debouncer: 2-FF sync, per-key stable-count debounce, press/release/long/repeat events.
// Events register on the commit edge, DEBOUNCE_CYCLES+2 edges after a clean raw change.
module key_debounce_multi #(
    parameter int KEY_WIDTH       = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int CNT_W           = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KEY_WIDTH-1:0] key_in,
    output logic [KEY_WIDTH-1:0] key_state,
    output logic [KEY_WIDTH-1:0] press_pulse,
    output logic [KEY_WIDTH-1:0] release_pulse,
    output logic [KEY_WIDTH-1:0] long_pulse,
    output logic [KEY_WIDTH-1:0] repeat_pulse,
    output logic                 key_flag,
    output logic [KEY_WIDTH-1:0] key_value
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {ST_REL, ST_PRS, ST_LNG} key_st_e;

    logic [KEY_WIDTH-1:0] key_norm;
    logic [KEY_WIDTH-1:0] sync1_q, sync2_q;
    logic [KEY_WIDTH-1:0] press_d;
    logic                 key_flag_q;
    logic [KEY_WIDTH-1:0] key_value_q;

    // Pressed = 1 from here on; sync flops reset to the released level.
    assign key_norm = ACTIVE_LOW ? ~key_in : key_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_norm;
            sync2_q <= sync1_q;
        end
    end

    for (genvar k = 0; k < KEY_WIDTH; k++) begin : g_key
        key_st_e          st_q, st_d;
        logic [CNT_W-1:0] dcnt_q, dcnt_d, hcnt_q, hcnt_d;
        logic             kst_q, kst_d, commit;
        logic             prs_q, prs_d, rel_q, rel_d, lng_q, lng_d, rpt_q, rpt_d;

        always_comb begin
            dcnt_d = '0;
            commit = 1'b0;
            kst_d  = kst_q;
            if (sync2_q[k] != kst_q) begin
                if (dcnt_q < DEB_LAST) begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end else begin
                    commit = 1'b1;
                    kst_d  = sync2_q[k];
                end
            end
        end

        // A release commit wins over a long/repeat terminal count in the same cycle.
        always_comb begin
            st_d   = st_q;
            hcnt_d = '0;
            prs_d  = 1'b0;
            rel_d  = 1'b0;
            lng_d  = 1'b0;
            rpt_d  = 1'b0;
            case (st_q)
                ST_REL: begin
                    if (commit && sync2_q[k]) begin
                        st_d  = ST_PRS;
                        prs_d = 1'b1;
                    end
                end
                ST_PRS: begin
                    if (commit && !sync2_q[k]) begin
                        st_d  = ST_REL;
                        rel_d = 1'b1;
                    end else if (hcnt_q == LONG_LAST) begin
                        st_d  = ST_LNG;
                        lng_d = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
                ST_LNG: begin
                    if (commit && !sync2_q[k]) begin
                        st_d  = ST_REL;
                        rel_d = 1'b1;
                    end else if (hcnt_q == REP_LAST) begin
                        rpt_d = REPEAT_EN;
                    end else begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
                default: st_d = ST_REL;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q   <= ST_REL;
                dcnt_q <= '0;
                hcnt_q <= '0;
                kst_q  <= 1'b0;
                prs_q  <= 1'b0;
                rel_q  <= 1'b0;
                lng_q  <= 1'b0;
                rpt_q  <= 1'b0;
            end else begin
                st_q   <= st_d;
                dcnt_q <= dcnt_d;
                hcnt_q <= hcnt_d;
                kst_q  <= kst_d;
                prs_q  <= prs_d;
                rel_q  <= rel_d;
                lng_q  <= lng_d;
                rpt_q  <= rpt_d;
            end
        end

        assign press_d[k]       = prs_d;
        assign key_state[k]     = kst_q;
        assign press_pulse[k]   = prs_q;
        assign release_pulse[k] = rel_q;
        assign long_pulse[k]    = lng_q;
        assign repeat_pulse[k]  = rpt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_flag_q  <= 1'b0;
            key_value_q <= '0;
        end else begin
            key_flag_q <= |press_d;
            if (|press_d) begin
                key_value_q <= press_d;
            end
        end
    end

    assign key_flag  = key_flag_q;
    assign key_value = key_value_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: three instances (active-low, active-low without repeat,
// active-high) share one stimulus and are checked every cycle against an event-level model.
module tb_key_debounce_multi;
    localparam int KW   = 4;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] kp    = '0;
    logic [KW-1:0] raw_al, raw_ah;
    assign raw_al = ~kp;
    assign raw_ah = kp;

    logic [KW-1:0] ks[3], pp[3], rp[3], lp[3], rr[3], kv[3];
    logic          kf[3];

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    key_debounce_multi #(.KEY_WIDTH(KW), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1), .CNT_W(26)) u0 (
        .clk(clk), .rst_n(rst_n), .key_in(raw_al), .key_state(ks[0]), .press_pulse(pp[0]),
        .release_pulse(rp[0]), .long_pulse(lp[0]), .repeat_pulse(rr[0]),
        .key_flag(kf[0]), .key_value(kv[0]));

    key_debounce_multi #(.KEY_WIDTH(KW), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0), .CNT_W(26)) u1 (
        .clk(clk), .rst_n(rst_n), .key_in(raw_al), .key_state(ks[1]), .press_pulse(pp[1]),
        .release_pulse(rp[1]), .long_pulse(lp[1]), .repeat_pulse(rr[1]),
        .key_flag(kf[1]), .key_value(kv[1]));

    key_debounce_multi #(.KEY_WIDTH(KW), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1), .CNT_W(26)) u2 (
        .clk(clk), .rst_n(rst_n), .key_in(raw_ah), .key_state(ks[2]), .press_pulse(pp[2]),
        .release_pulse(rp[2]), .long_pulse(lp[2]), .repeat_pulse(rr[2]),
        .key_flag(kf[2]), .key_value(kv[2]));

    // Event-level model: a committed level changes after DEB consecutive differing samples
    // of the synchronized input; long/repeat derive from cycles held since the press commit.
    logic [KW-1:0] m_s1, m_s2, m_st, m_prs, m_rel, m_lng, m_rpt, m_kv, m_cm;
    logic          m_flag;
    int            m_run[KW];
    int            m_held[KW];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_prs = '0; m_rel = '0;
            m_lng = '0; m_rpt = '0; m_kv = '0; m_flag = 1'b0; m_cm = '0;
            for (int k = 0; k < KW; k++) begin
                m_run[k]  = 0;
                m_held[k] = 0;
            end
        end else begin
            m_prs = '0; m_rel = '0; m_lng = '0; m_rpt = '0; m_cm = '0;
            for (int k = 0; k < KW; k++) begin
                if (m_s2[k] != m_st[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_cm[k]  = 1'b1;
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                if (m_cm[k]) begin
                    m_st[k] = m_s2[k];
                    if (m_s2[k]) begin
                        m_prs[k]  = 1'b1;
                        m_held[k] = 0;
                    end else begin
                        m_rel[k] = 1'b1;
                    end
                end else if (m_st[k]) begin
                    m_held[k]++;
                    if (m_held[k] == LONG)
                        m_lng[k] = 1'b1;
                    else if (m_held[k] > LONG && ((m_held[k] - LONG) % REP) == 0)
                        m_rpt[k] = 1'b1;
                end
            end
            m_flag = |m_prs;
            if (m_flag) m_kv = m_prs;
            m_s2 = m_s1;
            m_s1 = kp;
        end
    end

    task automatic chk(input string name, input int inst, input logic [KW-1:0] act,
                       input logic [KW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d got=%b want=%b", name, inst, cyc, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    int            press0_cyc = -1, long0_cyc = -1, rep0_first = -1, rel0_cyc = -1;
    int            rep0_cnt = 0, rep1_cnt = 0, long1_cnt = 0, flag_cnt = 0;
    logic [KW-1:0] pulse_seen = '0;
    logic [KW-1:0] rel_seen   = '0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 3; i++) begin
                chk("key_state", i, ks[i], m_st);
                chk("press_pulse", i, pp[i], m_prs);
                chk("release_pulse", i, rp[i], m_rel);
                chk("long_pulse", i, lp[i], m_lng);
                chk("repeat_pulse", i, rr[i], (i == 1) ? 4'b0000 : m_rpt);
                chk("key_flag", i, {3'b000, kf[i]}, {3'b000, m_flag});
                chk("key_value", i, kv[i], m_kv);
            end
            if (pp[0][0]) press0_cyc = cyc;
            if (lp[0][0]) long0_cyc = cyc;
            if (rr[0][0]) begin
                rep0_cnt++;
                if (rep0_first < 0) rep0_first = cyc;
            end
            if (rp[0][0]) rel0_cyc = cyc;
            if (rr[1][0]) rep1_cnt++;
            if (lp[1][0]) long1_cnt++;
            if (kf[0]) flag_cnt++;
            pulse_seen = pulse_seen | pp[0] | rp[0] | lp[0] | rr[0];
            rel_seen   = rel_seen | rp[0] | rp[2];
        end
    end

    // All bench actions happen 2 time units after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int c0, c1, c2;

    initial begin
        step(3);
        rst_n = 1'b1;
        step(2);

        // Single press on key 0: commit at the 6th edge after the change.
        kp[0] = 1'b1;
        c0 = cyc;
        step(5);
        chk("t1_before_commit", 0, ks[0], 4'b0000);
        step(1);
        chk("t1_state", 0, ks[0], 4'b0001);
        chk("t1_press", 0, pp[0], 4'b0001);
        chk("t1_flag", 0, {3'b000, kf[0]}, 4'b0001);
        chk("t1_value", 0, kv[0], 4'b0001);
        step(1);
        chki("t1_latency", press0_cyc - c0, 6);
        chk("t1_press_one_cycle", 0, pp[0], 4'b0000);
        chk("t1_flag_one_cycle", 0, {3'b000, kf[0]}, 4'b0000);
        chk("t1_value_held", 0, kv[0], 4'b0001);

        // Hold 60 cycles after commit, then release.
        step(58);
        kp[0] = 1'b0;
        c1 = cyc;
        step(20);
        chki("t3_long_after_press", long0_cyc - press0_cyc, LONG);
        chki("t3_first_repeat", rep0_first - long0_cyc, REP);
        chki("t3_repeat_count", rep0_cnt, 5);
        chki("t3_norepeat_count", rep1_cnt, 0);
        chki("t3_norepeat_long", long1_cnt, 1);
        chki("t3_release_latency", rel0_cyc - c1, 6);
        chk("t3_state_released", 0, ks[0], 4'b0000);

        // Key 1 bounces every 2 cycles: nothing may commit.
        pulse_seen = '0;
        for (int i = 0; i < 10; i++) begin
            kp[1] = ~kp[1];
            step(2);
        end
        step(10);
        chk("t2_state", 0, ks[0], 4'b0000);
        chk("t2_no_pulses", 0, pulse_seen, 4'b0000);

        // Keys 1 and 2 together.
        flag_cnt = 0;
        kp = 4'b0110;
        c2 = cyc;
        step(6);
        chk("t4_press", 0, pp[0], 4'b0110);
        chk("t4_flag", 0, {3'b000, kf[0]}, 4'b0001);
        chk("t4_value", 0, kv[0], 4'b0110);
        step(2);
        chki("t4_single_flag", flag_cnt, 1);
        chk("t4_value_held", 0, kv[0], 4'b0110);
        kp = 4'b0000;
        step(10);

        // Reset while key 3 is in the long/repeat phase, key still held afterwards.
        kp = 4'b1000;
        step(30);
        chk("t5_held", 0, ks[0], 4'b1000);
        rel_seen = '0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_state", 0, ks[0], 4'b0000);
        chk("t5_rst_value", 0, kv[0], 4'b0000);
        chk("t5_rst_flag", 0, {3'b000, kf[0]}, 4'b0000);
        step(2);
        chk("t5_rst_state_u2", 2, ks[2], 4'b0000);
        rst_n = 1'b1;
        step(5);
        chk("t5_pre_redetect", 0, ks[0], 4'b0000);
        step(1);
        chk("t5_redetect_press", 0, pp[0], 4'b1000);
        chk("t5_redetect_value", 0, kv[0], 4'b1000);
        step(1);
        chk("t5_no_release", 0, rel_seen, 4'b0000);
        kp = 4'b0000;
        step(10);

        // Active-high instance: press key 2, then a 3-cycle glitch while held.
        rel_seen = '0;
        kp = 4'b0100;
        step(6);
        chk("t6_state", 2, ks[2], 4'b0100);
        chk("t6_press", 2, pp[2], 4'b0100);
        step(2);
        kp = 4'b0000;
        step(3);
        kp = 4'b0100;
        step(10);
        chk("t6_state_after_glitch", 2, ks[2], 4'b0100);
        chk("t6_no_release", 2, rel_seen, 4'b0000);
        kp = 4'b0000;
        step(10);
        chk("t6_released", 2, ks[2], 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
